control_unit: RTL and testbench
===============================

# control_unit

Hardwired control sequencer for the single-bus 32-bit datapath. It replaces the hand-driven control waveforms used in the per-instruction benches. It runs fetch (T0–T2) and a per-opcode execute sequence, driving every datapath control strobe from its state register. It sits beside `Datapath`, takes `IR` and `CON_output` back from it, and owns run/halt.

## Interface
Parameters:
- `LINK_REG`, 8: register index written by `jal`, driven one-hot on `R_rd`.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `clr`  in  1  reset. Synchronous, active-high.
- `IR`  in  32  instruction register. Field positions:
  - opcode `[31:27]`
  - Ra `[26:23]`
  - Rb `[22:19]`
  - Rc `[18:15]`
- `CON_ff`  in  1  branch-condition flip-flop from datapath.
- `stop`  in  1  halt request, taken at the next instruction boundary.
- `run`  out  1  high while executing; low in reset and halt.
- `R_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out`  out  1 each  bus-drive strobes.
- `Rin, MARin, Zlowin, PCin, MDRin, IRin, Yin, CONin`  out  1 each  register-load strobes.
- `IncPC, Read, Write, Gra, Grb, Grc, BAout`  out  1 each  PC, memory and register-select controls.
- `op_sel`  out  5  ALU operation.
- `R_rd`  out  16  one-hot direct register select; nonzero only for the `jal` link write.

## Operation
Outputs are Moore outputs. They are decoded from state only and held for the whole cycle.

Every state not listed drives all outputs 0, except `run`.

**Fetch**
- T0: `PC_out`, `MARin`, `IncPC`, `Zlowin`.
- T1: `Zlo_out`, `PCin`, `Read`, `MDRin`.
- T2: `MDR_out`, `IRin`.

**Execute**
The opcode is taken from `IR` at the end of T2.
- ALU register ops (add 00011, sub 00100, and 00101, or 00110):
  - T3: `Grb`, `R_out`, `Yin`.
  - T4: `Grc`, `R_out`, `op_sel`=opcode, `Zlowin`.
  - T5: `Zlo_out`, `Gra`, `Rin`.
- addi 01011: T3 as for ALU ops; T4 `C_out`, `op_sel`=00011, `Zlowin`; T5 `Zlo_out`, `Gra`, `Rin`.
- ldi 00001: T3 `Grb`, `BAout`, `Yin`; T4 `C_out`, `op_sel`=00011, `Zlowin`; T5 `Zlo_out`, `Gra`, `Rin`.
- ld 00000: T3–T4 as ldi; T5 `Zlo_out`, `MARin`; T6 `Read`, `MDRin`; T7 `MDR_out`, `Gra`, `Rin`.
- st 00010: T3–T5 as ld; T6 `Gra`, `R_out`, `MDRin`; T7 `Write`.
- br 10010:
  - T3: `Gra`, `R_out`, `CONin`.
  - T4: `PC_out`, `Yin`.
  - T5: `C_out`, `op_sel`=00011, `Zlowin`.
  - T6: `Zlo_out`, plus `PCin` only if `CON_ff`=1.
- jr 10011: T3 `Gra`, `R_out`, `PCin`.
- jal 10100: T3 `PC_out`, `Rin`, `R_rd`[LINK_REG]=1; T4 `Gra`, `R_out`, `PCin`.
- mfhi 10111 / mflo 11000: T3 `HI_out` / `LO_out`, `Gra`, `Rin`.
- in 10101: T3 `In_out`, `Gra`, `Rin`.
- nop 11010, and every undefined opcode: no execute states; return to T0 after T2.
- halt 11011: enter HALT.

**State machine**
- States: RESET, T0–T7, HALT.
- RESET → T0.
- Fetch states run T0 → T1 → T2.
- Last execute state → T0, or → HALT if `stop`=1 in that cycle.
- HALT holds until `clr`.

## Timing
- `clr` sampled at a rising edge forces RESET on that edge. This applies from any state, including mid-instruction. A `Write` or `PCin` in progress is dropped.
- Reset values: all strobes 0, `op_sel`=0, `R_rd`=0, `run`=0.
- `run`=1 in T0–T7. `run`=0 in RESET and HALT.
- Instruction length in cycles, fetch included:
  - ALU / addi / ldi: 6
  - ld / st: 8
  - br: 7
  - jal: 5
  - jr / mfhi / mflo / in: 4
  - nop: 3
- `CON_ff` is used at T6 of br. `CON_ff` is written at T3, so the value used is the one loaded by that branch.
- `stop` is ignored except in the final state of an instruction. No instruction is ever split by `stop`.
- Only one bus driver is asserted per state, guaranteed by construction.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - opcode constants;
  - `op_sel` constants (ADD=00011, SUB=00100, AND=00101, OR=00110);
  - the state enum.
- Sub-module `instr_class_decode` (combinational): maps opcode to instruction class (ALU, IMM, LD, ST, BR, JR, JAL, MOVE, IN, NOP, HALT).
- The FSM keeps one state register and one output decode block.

## Test plan
- `clr`=1 for 2 cycles, then 0: all strobes 0 during reset; `run` rises on the cycle after; the first state is T0 with `PC_out`/`MARin`/`IncPC`/`Zlowin` high.
- IR=0x18918000 (add R1,R2,R3):
  - T4 `Grc`+`R_out`+`op_sel`=00011;
  - T5 `Zlo_out`+`Gra`+`Rin`;
  - back to T0 six cycles after the start.
- IR=0xA2800000 (jal R5):
  - T3 `PC_out`+`Rin` with `R_rd`=0x0100;
  - T4 `Gra`+`R_out`+`PCin`;
  - 5-cycle instruction.
- br with `CON_ff`=1, then with `CON_ff`=0: `PCin` high at T6 only in the first case; both take 7 cycles.
- st (opcode 00010): `Write` high exactly in T7; `clr` asserted during T6 gives RESET next cycle and `Write` never asserts.
- IR=0xD8000000 (halt), and separately `stop`=1 during the last state of an add: enters HALT; `run`=0 and all strobes 0 until `clr`.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, ALU-select, state and class definitions for the
// hardwired control sequencer.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LD, C_ST, C_BR, C_JR,
        C_JAL, C_MOVE, C_IN, C_NOP, C_HALT
    } cls_t;

    function automatic logic [4:0] alu_sel(input logic [4:0] op);
        case (op)
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            default: alu_sel = ALU_ADD;
        endcase
    endfunction

    // Final state of each class; nop/halt end at the last fetch state.
    function automatic state_t last_state(input cls_t c);
        case (c)
            C_ALU, C_IMM:        last_state = S_T5;
            C_LD, C_ST:          last_state = S_T7;
            C_BR:                last_state = S_T6;
            C_JAL:               last_state = S_T4;
            C_JR, C_MOVE, C_IN:  last_state = S_T3;
            default:             last_state = S_T2;
        endcase
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode-to-class map; undefined opcodes behave as nop.
module instr_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] i_opcode,
    output cls_t       o_cls
);

    always_comb begin
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: o_cls = C_ALU;
            OP_ADDI, OP_LDI:               o_cls = C_IMM;
            OP_LD:                         o_cls = C_LD;
            OP_ST:                         o_cls = C_ST;
            OP_BR:                         o_cls = C_BR;
            OP_JR:                         o_cls = C_JR;
            OP_JAL:                        o_cls = C_JAL;
            OP_MFHI, OP_MFLO:              o_cls = C_MOVE;
            OP_IN:                         o_cls = C_IN;
            OP_HALT:                       o_cls = C_HALT;
            default:                       o_cls = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving the single-bus datapath
// strobes as Moore outputs of the state register.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int LINK_REG = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_ff,
    input  logic        stop,
    output logic        run,
    output logic        R_out, HI_out, LO_out, Zhi_out, Zlo_out,
    output logic        PC_out, MDR_out, MAR_out, In_out, C_out,
    output logic        Rin, MARin, Zlowin, PCin, MDRin, IRin, Yin, CONin,
    output logic        IncPC, Read, Write, Gra, Grb, Grc, BAout,
    output logic [4:0]  op_sel,
    output logic [15:0] R_rd
);

    state_t     r_state;
    cls_t       r_cls;
    logic [4:0] r_op;
    cls_t       w_cls;
    logic       w_unused_ir;

    assign w_unused_ir = ^IR[26:0];

    instr_class_decode u_dec (
        .i_opcode (IR[31:27]),
        .o_cls    (w_cls)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_RESET;
            r_cls   <= C_NOP;
            r_op    <= '0;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_T0:    r_state <= S_T1;
                S_T1:    r_state <= S_T2;
                S_T2: begin
                    r_cls <= w_cls;
                    r_op  <= IR[31:27];
                    if (w_cls == C_HALT)
                        r_state <= S_HALT;
                    else if (w_cls == C_NOP)
                        r_state <= stop ? S_HALT : S_T0;
                    else
                        r_state <= S_T3;
                end
                S_HALT:  r_state <= S_HALT;
                default: begin
                    if (r_state == last_state(r_cls))
                        r_state <= stop ? S_HALT : S_T0;
                    else
                        r_state <= state_t'(r_state + 4'd1);
                end
            endcase
        end
    end

    always_comb begin
        {R_out, HI_out, LO_out, Zhi_out, Zlo_out} = '0;
        {PC_out, MDR_out, MAR_out, In_out, C_out} = '0;
        {Rin, MARin, Zlowin, PCin, MDRin, IRin, Yin, CONin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc, BAout} = '0;
        op_sel = '0;
        R_rd   = '0;
        run    = (r_state != S_RESET) && (r_state != S_HALT);
        case (r_state)
            S_T0: {PC_out, MARin, IncPC, Zlowin} = '1;
            S_T1: {Zlo_out, PCin, Read, MDRin} = '1;
            S_T2: {MDR_out, IRin} = '1;
            S_T3: begin
                case (r_cls)
                    C_ALU: {Grb, R_out, Yin} = '1;
                    C_IMM: begin
                        {Grb, Yin} = '1;
                        if (r_op == OP_LDI) BAout = 1'b1;
                        else                R_out = 1'b1;
                    end
                    C_LD, C_ST: {Grb, BAout, Yin} = '1;
                    C_BR:  {Gra, R_out, CONin} = '1;
                    C_JR:  {Gra, R_out, PCin} = '1;
                    C_JAL: begin
                        {PC_out, Rin} = '1;
                        R_rd = 16'd1 << LINK_REG;
                    end
                    C_MOVE: begin
                        {Gra, Rin} = '1;
                        if (r_op == OP_MFHI) HI_out = 1'b1;
                        else                 LO_out = 1'b1;
                    end
                    C_IN:  {In_out, Gra, Rin} = '1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (r_cls)
                    C_ALU: begin
                        {Grc, R_out, Zlowin} = '1;
                        op_sel = alu_sel(r_op);
                    end
                    C_IMM, C_LD, C_ST: begin
                        {C_out, Zlowin} = '1;
                        op_sel = ALU_ADD;
                    end
                    C_BR:  {PC_out, Yin} = '1;
                    C_JAL: {Gra, R_out, PCin} = '1;
                    default: ;
                endcase
            end
            S_T5: begin
                case (r_cls)
                    C_ALU, C_IMM: {Zlo_out, Gra, Rin} = '1;
                    C_LD, C_ST:   {Zlo_out, MARin} = '1;
                    C_BR: begin
                        {C_out, Zlowin} = '1;
                        op_sel = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (r_cls)
                    C_LD: {Read, MDRin} = '1;
                    C_ST: {Gra, R_out, MDRin} = '1;
                    C_BR: begin
                        Zlo_out = 1'b1;
                        PCin    = CON_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (r_cls)
                    C_LD: {MDR_out, Gra, Rin} = '1;
                    C_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction-stream bench for control_unit against a
// per-opcode strobe-sequence model.
module tb_control_unit;

    typedef struct packed {
        logic [4:0]  op_sel;
        logic [15:0] R_rd;
        logic        run;
        logic R_out, HI_out, LO_out, Zhi_out, Zlo_out;
        logic PC_out, MDR_out, MAR_out, In_out, C_out;
        logic Rin, MARin, Zlowin, PCin, MDRin, IRin, Yin, CONin;
        logic IncPC, Read, Write, Gra, Grb, Grc, BAout;
    } ctl_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] IR = '0;
    logic        CON_ff = 1'b0;
    logic        stop = 1'b0;
    ctl_t        dut;

    int total = 0;
    int bad   = 0;

    ctl_t exp_q[$];
    ctl_t plan[$];

    always #5 clk = ~clk;

    control_unit #(.LINK_REG(8)) u_dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_ff(CON_ff), .stop(stop),
        .run(dut.run),
        .R_out(dut.R_out), .HI_out(dut.HI_out), .LO_out(dut.LO_out),
        .Zhi_out(dut.Zhi_out), .Zlo_out(dut.Zlo_out),
        .PC_out(dut.PC_out), .MDR_out(dut.MDR_out),
        .MAR_out(dut.MAR_out), .In_out(dut.In_out), .C_out(dut.C_out),
        .Rin(dut.Rin), .MARin(dut.MARin), .Zlowin(dut.Zlowin),
        .PCin(dut.PCin), .MDRin(dut.MDRin), .IRin(dut.IRin),
        .Yin(dut.Yin), .CONin(dut.CONin),
        .IncPC(dut.IncPC), .Read(dut.Read), .Write(dut.Write),
        .Gra(dut.Gra), .Grb(dut.Grb), .Grc(dut.Grc), .BAout(dut.BAout),
        .op_sel(dut.op_sel), .R_rd(dut.R_rd)
    );

    function automatic ctl_t b();
        ctl_t r = '0;
        r.run = 1'b1;
        return r;
    endfunction

    // Builds the full per-cycle strobe list of one instruction.
    function automatic void model(input logic [4:0] op, input logic con);
        ctl_t r;
        plan.delete();
        r = b(); r.PC_out = 1; r.MARin = 1; r.IncPC = 1; r.Zlowin = 1;
        plan.push_back(r);
        r = b(); r.Zlo_out = 1; r.PCin = 1; r.Read = 1; r.MDRin = 1;
        plan.push_back(r);
        r = b(); r.MDR_out = 1; r.IRin = 1;
        plan.push_back(r);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                r = b(); r.Grb = 1; r.R_out = 1; r.Yin = 1; plan.push_back(r);
                r = b(); r.Grc = 1; r.R_out = 1; r.op_sel = op; r.Zlowin = 1;
                plan.push_back(r);
                r = b(); r.Zlo_out = 1; r.Gra = 1; r.Rin = 1; plan.push_back(r);
            end
            5'b01011, 5'b00001, 5'b00000, 5'b00010: begin
                r = b(); r.Grb = 1; r.Yin = 1;
                if (op == 5'b01011) r.R_out = 1; else r.BAout = 1;
                plan.push_back(r);
                r = b(); r.C_out = 1; r.op_sel = 5'b00011; r.Zlowin = 1;
                plan.push_back(r);
                r = b(); r.Zlo_out = 1;
                if (op == 5'b01011 || op == 5'b00001) begin
                    r.Gra = 1; r.Rin = 1; plan.push_back(r);
                end else begin
                    r.MARin = 1; plan.push_back(r);
                    r = b(); r.MDRin = 1;
                    if (op == 5'b00000) r.Read = 1;
                    else begin r.Gra = 1; r.R_out = 1; end
                    plan.push_back(r);
                    r = b();
                    if (op == 5'b00000) begin
                        r.MDR_out = 1; r.Gra = 1; r.Rin = 1;
                    end else r.Write = 1;
                    plan.push_back(r);
                end
            end
            5'b10010: begin
                r = b(); r.Gra = 1; r.R_out = 1; r.CONin = 1; plan.push_back(r);
                r = b(); r.PC_out = 1; r.Yin = 1; plan.push_back(r);
                r = b(); r.C_out = 1; r.op_sel = 5'b00011; r.Zlowin = 1;
                plan.push_back(r);
                r = b(); r.Zlo_out = 1; r.PCin = con; plan.push_back(r);
            end
            5'b10011: begin
                r = b(); r.Gra = 1; r.R_out = 1; r.PCin = 1; plan.push_back(r);
            end
            5'b10100: begin
                r = b(); r.PC_out = 1; r.Rin = 1; r.R_rd = 16'h0100;
                plan.push_back(r);
                r = b(); r.Gra = 1; r.R_out = 1; r.PCin = 1; plan.push_back(r);
            end
            5'b10111, 5'b11000, 5'b10101: begin
                r = b(); r.Gra = 1; r.Rin = 1;
                if (op == 5'b10111) r.HI_out = 1;
                else if (op == 5'b11000) r.LO_out = 1;
                else r.In_out = 1;
                plan.push_back(r);
            end
            default: ;
        endcase
    endfunction

    task automatic check_int(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    initial begin
        ctl_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (dut !== e) begin
                    bad++;
                    $display("FAIL ctl t=%0t got=%h want=%h", $time, dut, e);
                end
            end
        end
    end

    task automatic idle_slot(input logic c);
        @(negedge clk);
        clr = c;
        exp_q.push_back('0);
    endtask

    task automatic reset_slot();
        idle_slot(1'b1);
    endtask

    // Slot i pushes the state seen after the next rising edge; the
    // instruction inputs are applied while the machine sits in T0.
    task automatic run_instr(input logic [31:0] ir, input logic con,
                             input logic stp, input int abort);
        int ab;
        model(ir[31:27], con);
        ab = (abort >= plan.size()) ? -1 : abort;
        for (int i = 0; i < plan.size(); i++) begin
            @(negedge clk);
            if (i == 0) clr = 1'b0;
            if (i == 1) begin IR = ir; CON_ff = con; stop = stp; end
            if (i == ab) begin
                clr = 1'b1;
                exp_q.push_back('0);
                return;
            end
            exp_q.push_back(plan[i]);
        end
        if (ir[31:27] == 5'b11011 || stp) begin
            repeat (3) idle_slot(1'b0);
            reset_slot();
        end
    endtask

    initial begin
        logic [4:0] op;
        int ab;

        model(5'b00011, 1'b0); check_int("len_add", plan.size(), 6);
        check_int("add_t4_opsel", int'(plan[4].op_sel), 3);
        model(5'b10100, 1'b0); check_int("len_jal", plan.size(), 5);
        check_int("jal_rrd", int'(plan[3].R_rd), 256);
        model(5'b10010, 1'b1); check_int("len_br", plan.size(), 7);
        check_int("br1_pcin", int'(plan[6].PCin), 1);
        model(5'b10010, 1'b0); check_int("br0_pcin", int'(plan[6].PCin), 0);
        model(5'b00010, 1'b0); check_int("len_st", plan.size(), 8);
        check_int("st_write", int'(plan[7].Write), 1);
        model(5'b10011, 1'b0); check_int("len_jr", plan.size(), 4);
        model(5'b11010, 1'b0); check_int("len_nop", plan.size(), 3);
        model(5'b01111, 1'b0); check_int("len_undef", plan.size(), 3);

        reset_slot();
        reset_slot();
        run_instr(32'h18918000, 1'b0, 1'b0, -1);
        run_instr(32'hA2800000, 1'b0, 1'b0, -1);
        run_instr(32'h91000000, 1'b1, 1'b0, -1);
        run_instr(32'h91000000, 1'b0, 1'b0, -1);
        run_instr(32'h10880000, 1'b0, 1'b0, -1);
        run_instr(32'h10880000, 1'b0, 1'b0, 7);
        run_instr(32'h18918000, 1'b0, 1'b1, -1);
        run_instr(32'hD8000000, 1'b0, 1'b0, -1);
        run_instr(32'hD0000000, 1'b0, 1'b1, -1);

        for (int n = 0; n < 400; n++) begin
            op = 5'($urandom_range(0, 31));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : -1;
            run_instr({op, 27'($urandom)}, 1'($urandom),
                      ($urandom_range(0, 7) == 0), ab);
        end

        @(posedge clk);
        #2;
        check_int("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
